regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 16 x 32-bit register bank between two writeback requesters: A (ALU result) and B (load/memory result).
- Uses round-robin arbitration and drives a registered write port (wr_en/wr_rd/wr_data) straight into the bank's write/rd/data inputs.
- Keeps a pending-write scoreboard so the issue stage can detect RAW hazards on rs/rt and stall on WAW to the same register.

---
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port, shared by the
// ALU (A) and load (B) writeback paths. It also holds the pending-write
// scoreboard that the issue stage uses for RAW checks and WAW stalls.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a_valid,
    input  logic [ADDR_W-1:0] req_a_rd,
    input  logic [DATA_W-1:0] req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [ADDR_W-1:0] req_b_rd,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              req_b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_rd,
    output logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] chk_rs,
    input  logic [ADDR_W-1:0] chk_rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic [NREG-1:0]   busy_vec
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t           last_grant;
    logic            grant_a;
    logic            grant_b;
    logic            issue_ok;
    logic [NREG-1:0] busy_next;

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (req_a_valid && (!req_b_valid || last_grant == LAST_B)) begin
                grant_a = 1'b1;
            end else if (req_b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;

    assign issue_stall = issue_valid & busy_vec[issue_rd];
    assign issue_ok    = issue_valid & ~busy_vec[issue_rd];
    assign busy_rs     = busy_vec[chk_rs];
    assign busy_rt     = busy_vec[chk_rt];

    // Next scoreboard: clears from accepted writes first, so an issue set on the same register wins.
    always_comb begin
        busy_next = busy_vec;
        if (grant_a) begin
            busy_next[req_a_rd] = 1'b0;
        end
        if (grant_b) begin
            busy_next[req_b_rd] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Register the write port, the round-robin pointer and the scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_rd      <= '0;
            wr_data    <= '0;
            busy_vec   <= '0;
            last_grant <= LAST_B;
        end else begin
            wr_en    <= grant_a | grant_b;
            busy_vec <= busy_next;
            if (grant_a) begin
                wr_rd      <= req_a_rd;
                wr_data    <= req_a_data;
                last_grant <= LAST_A;
            end else if (grant_b) begin
                wr_rd      <= req_b_rd;
                wr_data    <= req_b_data;
                last_grant <= LAST_B;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed plan cases followed by
// randomized traffic, checked against a behavioural model of grants, writes
// and the pending-write set.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a_valid, req_b_valid;
    logic [3:0]  req_a_rd, req_b_rd;
    logic [31:0] req_a_data, req_b_data;
    logic        req_a_ready, req_b_ready;
    logic        wr_en;
    logic [3:0]  wr_rd;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_stall;
    logic [3:0]  chk_rs, chk_rt;
    logic        busy_rs, busy_rt;
    logic [15:0] busy_vec;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4), .NREG(16)) dut (
        .clk(clk), .reset(reset),
        .req_a_valid(req_a_valid), .req_a_rd(req_a_rd), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_rd(req_b_rd), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          model_known = 1'b0;
    bit          m_last_b;
    bit          m_busy[16];
    bit          acc_a, acc_b;
    logic [3:0]  hold_rd;
    logic [31:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_busy();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One cycle: drive inputs after the edge, check combinational outputs
    // against the model, then advance the model to what the next edge does.
    task automatic step(input bit rst,
                        input bit av, input logic [3:0] ard, input logic [31:0] adat,
                        input bit bv, input logic [3:0] brd, input logic [31:0] bdat,
                        input bit iv, input logic [3:0] ird,
                        input logic [3:0] rs, input logic [3:0] rt);
        bit ga, gb, stall;
        @(posedge clk);
        #1;
        reset = rst;
        req_a_valid = av; req_a_rd = ard; req_a_data = adat;
        req_b_valid = bv; req_b_rd = brd; req_b_data = bdat;
        issue_valid = iv; issue_rd = ird;
        chk_rs = rs; chk_rt = rt;
        #3;
        // Lone requester wins; a tie goes to whoever did not win last time.
        ga = !rst && av && (!bv || m_last_b);
        gb = !rst && bv && !ga;
        check("ready_a", req_a_ready, ga);
        check("ready_b", req_b_ready, gb);
        stall = 1'b0;
        if (model_known) begin
            stall = iv && m_busy[ird];
            check("busy_vec", busy_vec, pack_busy());
            check("issue_stall", issue_stall, stall);
            check("busy_rs", busy_rs, m_busy[rs]);
            check("busy_rt", busy_rt, m_busy[rt]);
        end
        acc_a = ga;
        acc_b = gb;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_last_b    = 1'b1;
            hold_rd     = '0;
            hold_data   = '0;
            model_known = 1'b1;
        end else begin
            if (ga) begin
                exp_q.push_back('{rd: ard, data: adat});
                m_busy[ard] = 1'b0;
                m_last_b = 1'b0;
            end
            if (gb) begin
                exp_q.push_back('{rd: brd, data: bdat});
                m_busy[brd] = 1'b0;
                m_last_b = 1'b1;
            end
            if (iv && !stall) m_busy[ird] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, 4'd0, 4'd0);
    endtask

    // Monitor: each cycle either one expected write appears, or the port is idle and holding.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (model_known) begin
                if (wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("wr_en_spurious", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_rd", wr_rd, e.rd);
                        check("wr_data", wr_data, e.data);
                        hold_rd   = e.rd;
                        hold_data = e.data;
                    end
                end else begin
                    check("wr_en_missing", exp_q.size(), 64'd0);
                    check("wr_rd_hold", wr_rd, hold_rd);
                    check("wr_data_hold", wr_data, hold_data);
                end
            end
        end
    end

    initial begin
        bit         av, bv, rst;
        logic [3:0] ard, brd;
        logic [31:0] adat, bdat;
        reset = 1'b1;
        req_a_valid = 0; req_b_valid = 0; issue_valid = 0;
        req_a_rd = 0; req_b_rd = 0; req_a_data = 0; req_b_data = 0;
        issue_rd = 0; chk_rs = 0; chk_rt = 0;
        m_last_b = 1'b1;
        foreach (m_busy[i]) m_busy[i] = 1'b0;

        step(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, 4'd0, 4'd0);
        step(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, 4'd0, 4'd0);

        // A alone, single write.
        step(0, 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0, 0, 4'd0, 4'd3, 4'd0);
        idle(2);
        // Both continuously valid: alternation.
        for (int i = 0; i < 4; i++)
            step(0, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 0, 4'd0, 4'd1, 4'd2);
        idle(1);
        // Issue to r5, WAW stall on re-issue, then A clears it.
        step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd5, 4'd5, 4'd0);
        step(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd5, 4'd5, 4'd5);
        step(0, 1, 4'd5, 32'h55, 0, 4'd0, 32'd0, 0, 4'd0, 4'd5, 4'd0);
        idle(1);
        // r7 not busy: issue and B write on the same edge, the set wins.
        step(0, 0, 4'd0, 32'd0, 1, 4'd7, 32'h77, 1, 4'd7, 4'd7, 4'd7);
        // r7 busy: re-issue stalls, so only the clear takes effect.
        step(0, 0, 4'd0, 32'd0, 1, 4'd7, 32'h78, 1, 4'd7, 4'd7, 4'd0);
        idle(1);
        // Accept A then reset; after release a tie goes to A.
        step(0, 1, 4'd9, 32'h99, 0, 4'd0, 32'd0, 1, 4'd9, 4'd9, 4'd0);
        step(1, 1, 4'd9, 32'h99, 1, 4'd4, 32'h44, 1, 4'd2, 4'd9, 4'd0);
        step(1, 1, 4'd9, 32'h99, 1, 4'd4, 32'h44, 0, 4'd0, 4'd9, 4'd0);
        step(0, 1, 4'd9, 32'h99, 1, 4'd4, 32'h44, 0, 4'd0, 4'd9, 4'd4);
        idle(1);
        // B granted, idle gap, then a tie goes to A.
        step(0, 0, 4'd0, 32'd0, 1, 4'd6, 32'h66, 0, 4'd0, 4'd0, 4'd0);
        idle(3);
        step(0, 1, 4'd8, 32'h88, 1, 4'd6, 32'h67, 0, 4'd0, 4'd8, 4'd6);
        idle(1);

        // Randomized traffic; a requester refused last cycle holds its request.
        av = 0; bv = 0; ard = 0; brd = 0; adat = 0; bdat = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(av && !acc_a)) begin
                av = ($urandom_range(0, 2) != 0);
                ard = 4'($urandom_range(0, 15));
                adat = $urandom;
            end
            if (!(bv && !acc_b)) begin
                bv = ($urandom_range(0, 2) != 0);
                brd = 4'($urandom_range(0, 15));
                bdat = $urandom;
            end
            step(rst, av, ard, adat, bv, brd, bdat,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (rst) begin
                av = 0;
                bv = 0;
            end
        end

        idle(2);
        @(posedge clk);
        #3;
        check("queue_drain", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
